// File: rtl/lru_set_ctrl.sv
// Lookup/refill controller for one 8-way cache set.
// Compares a request tag against the set, picks a victim on a miss, and drives the LRU update.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | ready for a request or a flush
// LOOKUP  | compare the latched tag against all ways, choose a way
// REFILL  | refill request held until the next level acks
// UPDATE  | one-cycle LRU strobe and response
module lru_set_ctrl #(
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic             i_flush,
  output logic             o_resp_valid,
  output logic             o_resp_hit,
  output logic [7:0]       o_resp_way,
  output logic             o_refill_req,
  output logic [TAG_W-1:0] o_refill_tag,
  input  logic             i_refill_ack,
  input  logic [7:0]       i_lru_flag,
  output logic [7:0]       o_hit_way_8,
  output logic             o_hit_sig,
  output logic             o_lru_write_enable
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [8];
  logic [TAG_W-1:0] tag_d [8];
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [7:0]       way_q, way_d;
  logic             hit_q, hit_d;
  logic             promote_q, promote_d;

  logic [7:0]       hit_vec;
  logic [7:0]       inv_vec;
  logic [7:0]       low_inv;
  logic             lru_onehot;

  always_comb begin
    hit_vec = 8'd0;
    for (int i = 0; i < 8; i++) begin
      hit_vec[i] = valid_q[i] && (tag_q[i] == req_tag_q);
    end
  end

  // Two's-complement trick isolates the lowest set bit of the invalid mask.
  assign inv_vec    = ~valid_q;
  assign low_inv    = inv_vec & (~inv_vec + 8'd1);
  assign lru_onehot = (i_lru_flag != 8'd0) && ((i_lru_flag & (i_lru_flag - 8'd1)) == 8'd0);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    req_tag_d = req_tag_q;
    way_d     = way_q;
    hit_d     = hit_q;
    promote_d = promote_q;

    case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          valid_d = 8'd0;
        end else if (i_req_valid) begin
          req_tag_d = i_req_tag;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_vec != 8'd0) begin
          way_d     = hit_vec;
          hit_d     = 1'b1;
          promote_d = 1'b1;
          state_d   = S_UPDATE;
        end else if (inv_vec != 8'd0) begin
          way_d     = low_inv;
          hit_d     = 1'b0;
          promote_d = 1'b1;
          state_d   = S_REFILL;
        end else begin
          way_d     = lru_onehot ? i_lru_flag : 8'h01;
          hit_d     = 1'b0;
          promote_d = 1'b0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (i_refill_ack) begin
          for (int i = 0; i < 8; i++) begin
            if (way_q[i]) tag_d[i] = req_tag_q;
          end
          valid_d = valid_q | way_q;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      valid_q   <= 8'd0;
      req_tag_q <= '0;
      way_q     <= 8'd0;
      hit_q     <= 1'b0;
      promote_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      req_tag_q <= req_tag_d;
      way_q     <= way_d;
      hit_q     <= hit_d;
      promote_q <= promote_d;
      tag_q     <= tag_d;
    end
  end

  // Refill outputs decode straight from state so an async reset drops them at once.
  assign o_req_ready        = (state_q == S_IDLE) && !i_flush;
  assign o_refill_req       = (state_q == S_REFILL);
  assign o_refill_tag       = (state_q == S_REFILL) ? req_tag_q : '0;
  assign o_lru_write_enable = (state_q == S_UPDATE);
  assign o_hit_way_8        = (state_q == S_UPDATE) ? way_q : 8'd0;
  assign o_hit_sig          = (state_q == S_UPDATE) && promote_q;
  assign o_resp_valid       = (state_q == S_UPDATE);
  assign o_resp_hit         = (state_q == S_UPDATE) && hit_q;
  assign o_resp_way         = (state_q == S_UPDATE) ? way_q : 8'd0;

endmodule

// File: tb/tb_lru_set_ctrl.sv
// Directed bench for lru_set_ctrl: fills, hits, LRU/invalid victims, flush and reset.
module tb_lru_set_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [19:0] req_tag = '0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  lru_flag = 8'd0;

  logic        o_req_ready, o_resp_valid, o_resp_hit, o_refill_req;
  logic        o_hit_sig, o_lru_write_enable;
  logic [7:0]  o_resp_way, o_hit_way_8;
  logic [19:0] o_refill_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lru_set_ctrl #(.TAG_W(20)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_tag(req_tag),
    .i_flush(flush),
    .o_resp_valid(o_resp_valid), .o_resp_hit(o_resp_hit), .o_resp_way(o_resp_way),
    .o_refill_req(o_refill_req), .o_refill_tag(o_refill_tag), .i_refill_ack(ack),
    .i_lru_flag(lru_flag),
    .o_hit_way_8(o_hit_way_8), .o_hit_sig(o_hit_sig), .o_lru_write_enable(o_lru_write_enable)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; ack = 1'b0; lru_flag = 8'd0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Issues one request from IDLE, acks the refill ack_dly cycles after o_refill_req rises,
  // and returns the outputs seen in the response cycle.
  task automatic run_req(input logic [19:0] tag, input int ack_dly,
                         output logic got, output logic hit, output logic [7:0] way,
                         output logic [7:0] hw8, output logic hs, output logic lwe,
                         output int lat, output int ack_lat, output logic rt_ok);
    int n, w, n_ack;
    n = 0; w = 0; n_ack = -1; rt_ok = 1'b1;
    req_valid = 1'b1; req_tag = tag;
    tick();
    req_valid = 1'b0;
    while (!o_resp_valid && n < 60) begin
      if (o_refill_req) begin
        if (o_refill_tag !== tag) rt_ok = 1'b0;
        if (w == ack_dly) begin ack = 1'b1; n_ack = n; end
        else w++;
      end
      tick();
      ack = 1'b0;
      n++;
    end
    got = o_resp_valid; hit = o_resp_hit; way = o_resp_way;
    hw8 = o_hit_way_8; hs = o_hit_sig; lwe = o_lru_write_enable;
    lat = n + 1; ack_lat = n - n_ack;
  endtask

  logic       g, h, hs, lwe, rt;
  logic [7:0] way, hw8;
  int         lat, alat;

  task automatic test_reset_fill();
    do_reset();
    n_cmp++; if (o_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", o_req_ready); end
    n_cmp++;
    if ({o_resp_valid, o_resp_hit, o_resp_way, o_refill_req, o_refill_tag, o_hit_way_8, o_hit_sig, o_lru_write_enable} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got nonzero outputs want all 0");
    end
    run_req(20'h00010, 3, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL fill0_resp got=%b want=1", g); end
    n_cmp++; if ({h, way, hw8, hs, lwe} !== {1'b0, 8'h01, 8'h01, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL fill0_update got hit=%b way=%h hw8=%h hs=%b lwe=%b want 0 01 01 1 1", h, way, hw8, hs, lwe); end
    n_cmp++; if (alat !== 1) begin n_bad++; $display("FAIL fill0_ack_latency got=%0d want=1", alat); end
    n_cmp++; if (rt !== 1'b1) begin n_bad++; $display("FAIL fill0_refill_tag got bad tag during refill want 00010"); end
    tick();
    n_cmp++; if ({o_resp_valid, o_lru_write_enable} !== 2'b00) begin
      n_bad++; $display("FAIL fill0_single_pulse got rv=%b lwe=%b want 0 0", o_resp_valid, o_lru_write_enable); end
    run_req(20'h00010, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way} !== {1'b1, 1'b1, 8'h01}) begin
      n_bad++; $display("FAIL fill0_rehit got v=%b hit=%b way=%h want 1 1 01", g, h, way); end
  endtask

  task automatic test_hit();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      run_req(20'(i), 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
      n_cmp++; if ({g, h, way} !== {1'b1, 1'b0, 8'(8'h01 << (i - 1))}) begin
        n_bad++; $display("FAIL fill_way tag=%0d got v=%b hit=%b way=%h want 1 0 %h", i, g, h, way, 8'(8'h01 << (i - 1))); end
      tick();
    end
    run_req(20'h6, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way, hw8, hs, lwe} !== {1'b1, 1'b1, 8'h20, 8'h20, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL hit6 got v=%b hit=%b way=%h hw8=%h hs=%b lwe=%b want 1 1 20 20 1 1", g, h, way, hw8, hs, lwe); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hit6_latency got=%0d want=2", lat); end
    tick();
    n_cmp++; if (o_lru_write_enable !== 1'b0) begin n_bad++; $display("FAIL hit6_single_pulse got lwe=%b want 0", o_lru_write_enable); end
  endtask

  task automatic test_lru_victim();
    lru_flag = 8'h08;
    run_req(20'h9, 1, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way, hw8, hs} !== {1'b1, 1'b0, 8'h08, 8'h08, 1'b0}) begin
      n_bad++; $display("FAIL lru_victim got v=%b hit=%b way=%h hw8=%h hs=%b want 1 0 08 08 0", g, h, way, hw8, hs); end
    tick();
    run_req(20'h9, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way} !== {1'b1, 1'b1, 8'h08}) begin
      n_bad++; $display("FAIL new9_hit got v=%b hit=%b way=%h want 1 1 08", g, h, way); end
    tick();
    run_req(20'h4, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h} !== 2'b10) begin n_bad++; $display("FAIL old4_miss got v=%b hit=%b want 1 0", g, h); end
    lru_flag = 8'd0;
    tick();
  endtask

  task automatic test_flush();
    flush = 1'b1; req_valid = 1'b1; req_tag = 20'h55;
    #1;
    n_cmp++; if (o_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%b want=0", o_req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++; if (o_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_not_taken got ready=%b want 1", o_req_ready); end
    tick();
    n_cmp++; if ({o_refill_req, o_resp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL flush_idle got rr=%b rv=%b want 0 0", o_refill_req, o_resp_valid); end
    run_req(20'h55, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way, hs} !== {1'b1, 1'b0, 8'h01, 1'b1}) begin
      n_bad++; $display("FAIL post_flush_fill got v=%b hit=%b way=%h hs=%b want 1 0 01 1", g, h, way, hs); end
    tick();
  endtask

  task automatic test_reset_mid_refill();
    int n;
    do_reset();
    run_req(20'hA, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    tick();
    req_valid = 1'b1; req_tag = 20'hB;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!o_refill_req && n < 10) begin tick(); n++; end
    n_cmp++; if (o_refill_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_enter_refill got=%b want=1", o_refill_req); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if ({o_refill_req, o_req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_async got rr=%b ready=%b want 0 1", o_refill_req, o_req_ready); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (o_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got=%b want=1", o_req_ready); end
    run_req(20'hA, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way} !== {1'b1, 1'b0, 8'h01}) begin
      n_bad++; $display("FAIL rst_mid_tags_gone got v=%b hit=%b way=%h want 1 0 01", g, h, way); end
    tick();
  endtask

  task automatic test_ack_ignored_and_default_victim();
    do_reset();
    req_valid = 1'b1; req_tag = 20'h100;
    tick();
    req_valid = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if ({o_refill_req, o_resp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL lookup_ack_ignored got rr=%b rv=%b want 1 0", o_refill_req, o_resp_valid); end
    tick();
    n_cmp++; if ({o_refill_req, o_refill_tag} !== {1'b1, 20'h100}) begin
      n_bad++; $display("FAIL refill_hold got rr=%b tag=%h want 1 00100", o_refill_req, o_refill_tag); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if ({o_resp_valid, o_resp_hit, o_resp_way} !== {1'b1, 1'b0, 8'h01}) begin
      n_bad++; $display("FAIL late_ack_resp got v=%b hit=%b way=%h want 1 0 01", o_resp_valid, o_resp_hit, o_resp_way); end
    tick();
    for (int i = 1; i < 8; i++) begin
      run_req(20'h100 + 20'(i), 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
      tick();
    end
    lru_flag = 8'h00;
    run_req(20'h200, 0, g, h, way, hw8, hs, lwe, lat, alat, rt);
    n_cmp++; if ({g, h, way, hw8, hs} !== {1'b1, 1'b0, 8'h01, 8'h01, 1'b0}) begin
      n_bad++; $display("FAIL default_victim got v=%b hit=%b way=%h hw8=%h hs=%b want 1 0 01 01 0", g, h, way, hw8, hs); end
    tick();
  endtask

  initial begin
    test_reset_fill();
    test_hit();
    test_lru_victim();
    test_flush();
    test_reset_mid_refill();
    test_ack_ignored_and_default_victim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
